dial_quad_gen: RTL and testbench
================================

DIAL_QUAD_GEN -- requirements
Module: dial_quad_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent dial channels.
REQ-002 SHALL have parameter DIV_W, default 5: prescaler width; one step tick every 2^DIV_W enabled cycles.
REQ-003 SHALL have parameter POS_W, default 8: width of each channel position counter.
REQ-004 SHALL have ports:
- clk_sys  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable for the prescaler.
- quad_mode  input  1  0 = pulse mode, 1 = quadrature mode.
- inc  input  CHANNELS  per-channel increment request (level).
- dec  input  CHANNELS  per-channel decrement request (level).
- invert  input  CHANNELS  per-channel direction swap.
- dial  output  2*CHANNELS  channel n on bits [2n+1:2n], active-low encoding.
- pos  output  POS_W*CHANNELS  channel n signed position on bits [POS_W*(n+1)-1:POS_W*n].

Function
REQ-005 Prescaler SHALL count only when ce=1, wrap 2^DIV_W-1 -> 0, and assert a one-cycle tick when it is 0 and ce=1. All channels SHALL share this tick.
REQ-006 The effective direction SHALL be computed as follows:
- inc XOR invert selects up; dec XOR invert selects down (invert swaps the inc/dec roles).
- inc=dec=1 on the same tick SHALL produce no step.
REQ-007 Pulse mode SHALL use per-channel states IDLE, PULSE and REST:
- IDLE, tick with up -> PULSE, dial=10.
- IDLE, tick with down -> PULSE, dial=01.
- PULSE, tick -> REST, dial=11.
- REST, tick -> IDLE; an up or down request on this tick SHALL be ignored.
- IDLE, tick with no request -> stay IDLE, dial=11.
REQ-008 Quadrature mode SHALL step the 2-bit phase on each stepping tick:
- up: 11 -> 10 -> 00 -> 01 -> 11.
- down: the reverse sequence.
- no step: hold the current phase.
- dial SHALL equal the phase.
REQ-009 pos SHALL update on every step:
- +1 per up step; -1 per down step.
- In pulse mode, one step per PULSE entry; in quadrature mode, one step per phase change.
- pos SHALL wrap modulo 2^POS_W (7F+1=80, 00-1=FF for POS_W=8).
REQ-010 dial and pos SHALL be registered; they SHALL change on the clk_sys edge at which tick is asserted, i.e. 1-cycle latency from tick.
REQ-011 On any change of quad_mode, every channel SHALL, on the next clock:
- return to IDLE;
- set phase and dial to 11;
- keep pos unchanged.
REQ-012 A request deasserted between ticks SHALL have no effect; requests are sampled only at a tick.

Reset
REQ-013 On reset_n low, asynchronously:
- prescaler = 0;
- all channel states = IDLE;
- dial = all ones;
- pos = 0;
- acceleration counters = 0.
REQ-014 The first tick after reset_n deasserts SHALL occur on the first ce=1 cycle, since the prescaler is 0.

Configuration
REQ-015 Macro DIAL_ACCEL_EN SHALL compile in acceleration.
REQ-016 With DIAL_ACCEL_EN, each channel SHALL rate-limit steps:
- Each channel SHALL keep a held-step counter that saturates at 16.
- counter < 8: step on every 4th qualifying tick.
- counter 8..15: step on every 2nd qualifying tick.
- counter = 16: step on every qualifying tick.
- The counter SHALL clear on a tick with no request, on a direction reversal, on a mode change, or on reset.
REQ-017 Without DIAL_ACCEL_EN, every qualifying tick SHALL step, and no acceleration registers SHALL exist.

Structure
REQ-018 Package dial_pkg SHALL hold:
- the channel state enum (IDLE/PULSE/REST);
- the quadrature next-phase tables for up and down;
- the idle code 2'b11;
- the acceleration thresholds 8 and 16 and the divide ratios 4/2/1.
REQ-019 Per-channel logic SHALL be sub-module dial_channel, generated CHANNELS times. The prescaler SHALL reside in dial_quad_gen.

Verification
REQ-020 Pulse mode, DIV_W=5, ce=1, inc[0] held: dial[1:0] SHALL follow 11 -> 10 at cycle 1 -> 11 at cycle 33 -> 11 at cycle 65 -> 10 at cycle 97, and pos0 SHALL equal 2 after cycle 97.
REQ-021 Quad mode, dec[1] held for 4 ticks: dial[3:2] SHALL follow 11 -> 01 -> 00 -> 10 -> 11, and pos1 SHALL equal FC.
REQ-022 inc[0]=dec[0]=1 for 10 ticks: dial SHALL remain 11 and pos SHALL remain 0. With invert[0]=1 and only inc[0]=1, pos SHALL decrement.
REQ-023 pos=7F with one up step SHALL give 80; pos=00 with one down step SHALL give FF.
REQ-024 reset_n pulsed low mid-PULSE: dial SHALL go to 11 and pos to 0 immediately. quad_mode toggled mid-sequence: dial SHALL be 11 next clock and pos SHALL be unchanged.
REQ-025 With DIAL_ACCEL_EN, inc held for 40 ticks SHALL give step spacing of 4 ticks, then 2, then 1 at the thresholds, and the spacing SHALL return to 4 after a one-tick release.

Source files
------------

// File: rtl/dial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dial_pkg
// Description : Shared types and constants for the dial quadrature generator.
// Revision    : 1.0 - initial release
// ============================================================================
package dial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_REST  = 2'b10
    } chan_state_t;

    localparam logic [1:0] C_IDLE_CODE = 2'b11;
    localparam logic [1:0] C_PULSE_UP  = 2'b10;
    localparam logic [1:0] C_PULSE_DN  = 2'b01;

    // Indexed by the current phase; up walks 11->10->00->01->11
    localparam logic [1:0] C_QUAD_UP [0:3] = '{2'b01, 2'b11, 2'b00, 2'b10};
    localparam logic [1:0] C_QUAD_DN [0:3] = '{2'b10, 2'b00, 2'b11, 2'b01};

    localparam int C_ACCEL_MID = 8;
    localparam int C_ACCEL_MAX = 16;
    localparam int C_DIV_SLOW  = 4;
    localparam int C_DIV_MID   = 2;
    localparam int C_DIV_FAST  = 1;
    localparam int C_HELD_W    = 5;

    function automatic logic [1:0] quad_next(input logic [1:0] phase, input logic up);
        return up ? C_QUAD_UP[phase] : C_QUAD_DN[phase];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dial_channel.sv
`default_nettype none
// ============================================================================
// Module      : dial_channel
// Description : One dial channel: pulse/quadrature output FSM and position
//               counter; optional step acceleration under DIAL_ACCEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dial_channel
    import dial_pkg::*;
#(
    parameter int POS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_mode_change,
    input  logic             i_quad_mode,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_invert,
    output logic [1:0]       o_dial,
    output logic [POS_W-1:0] o_pos
);

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [1:0]       r_dial;
    logic [1:0]       w_dial_nxt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nxt;
    logic [POS_W-1:0] w_pos_step;
    logic             w_up;
    logic             w_dn;
    logic             w_req;
    logic             w_allow;

    // Both directions active (after inversion) cancel to no request
    assign w_up       = (i_inc ^ i_invert) & ~(i_dec ^ i_invert);
    assign w_dn       = (i_dec ^ i_invert) & ~(i_inc ^ i_invert);
    assign w_req      = w_up | w_dn;
    assign w_pos_step = w_up ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));

`ifdef DIAL_ACCEL_EN
    logic [C_HELD_W-1:0] r_held;
    logic [C_HELD_W-1:0] w_held_base;
    logic [1:0]          r_div;
    logic [1:0]          w_div_base;
    logic [1:0]          w_div_mask;
    logic                r_last_up;
    logic                w_fresh;

    // A reversal restarts the run exactly like a freshly held request
    assign w_fresh     = (r_held == '0) || (r_last_up != w_up);
    assign w_held_base = w_fresh ? '0 : r_held;
    assign w_div_base  = w_fresh ? '0 : r_div;
    assign w_allow     = (w_div_base == 2'b00);

    always_comb begin
        w_div_mask = 2'(C_DIV_SLOW - 1);
        if (w_held_base >= C_HELD_W'(C_ACCEL_MAX)) begin
            w_div_mask = 2'(C_DIV_FAST - 1);
        end else if (w_held_base >= C_HELD_W'(C_ACCEL_MID)) begin
            w_div_mask = 2'(C_DIV_MID - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held    <= '0;
            r_div     <= '0;
            r_last_up <= 1'b0;
        end else if (i_mode_change) begin
            r_held <= '0;
            r_div  <= '0;
        end else if (i_tick) begin
            if (!w_req) begin
                r_held <= '0;
                r_div  <= '0;
            end else begin
                r_held    <= (w_held_base >= C_HELD_W'(C_ACCEL_MAX)) ?
                             w_held_base : (w_held_base + C_HELD_W'(1));
                r_div     <= (w_div_base + 2'b01) & w_div_mask;
                r_last_up <= w_up;
            end
        end
    end
`else
    assign w_allow = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dial  <= C_IDLE_CODE;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dial  <= w_dial_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dial_nxt  = r_dial;
        w_pos_nxt   = r_pos;
        if (i_mode_change) begin
            w_state_nxt = ST_IDLE;
            w_dial_nxt  = C_IDLE_CODE;
        end else if (i_tick) begin
            if (i_quad_mode) begin
                // In quadrature mode the dial register itself holds the phase
                w_state_nxt = ST_IDLE;
                if (w_req && w_allow) begin
                    w_dial_nxt = quad_next(r_dial, w_up);
                    w_pos_nxt  = w_pos_step;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_req && w_allow) begin
                            w_state_nxt = ST_PULSE;
                            w_dial_nxt  = w_up ? C_PULSE_UP : C_PULSE_DN;
                            w_pos_nxt   = w_pos_step;
                        end else begin
                            w_dial_nxt = C_IDLE_CODE;
                        end
                    end
                    ST_PULSE: begin
                        w_state_nxt = ST_REST;
                        w_dial_nxt  = C_IDLE_CODE;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_dial_nxt  = C_IDLE_CODE;
                    end
                endcase
            end
        end
    end

    assign o_dial = r_dial;
    assign o_pos  = r_pos;

endmodule
`default_nettype wire

// File: rtl/dial_quad_gen.sv
`default_nettype none
// ============================================================================
// Module      : dial_quad_gen
// Description : Multi-channel dial pulse/quadrature generator with shared
//               prescaler. Define DIAL_ACCEL_EN to build step acceleration.
// Revision    : 1.0 - initial release
// ============================================================================
module dial_quad_gen
    import dial_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 5,
    parameter int POS_W    = 8
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic                      quad_mode,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic [CHANNELS-1:0]       invert,
    output logic [2*CHANNELS-1:0]     dial,
    output logic [POS_W*CHANNELS-1:0] pos
);

    logic [DIV_W-1:0] r_prescale;
    logic             r_mode_prev;
    logic             r_mode_vld;
    logic             w_tick;
    logic             w_mode_change;

    // r_mode_vld masks the first clock after reset, when r_mode_prev is not yet real
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale  <= '0;
            r_mode_prev <= 1'b0;
            r_mode_vld  <= 1'b0;
        end else begin
            if (ce) begin
                r_prescale <= r_prescale + DIV_W'(1);
            end
            r_mode_prev <= quad_mode;
            r_mode_vld  <= 1'b1;
        end
    end

    assign w_tick        = ce && (r_prescale == '0);
    assign w_mode_change = r_mode_vld && (quad_mode != r_mode_prev);

    generate
        for (genvar n = 0; n < CHANNELS; n++) begin : g_channel
            dial_channel #(
                .POS_W (POS_W)
            ) u_channel (
                .clk           (clk_sys),
                .rst_n         (reset_n),
                .i_tick        (w_tick),
                .i_mode_change (w_mode_change),
                .i_quad_mode   (quad_mode),
                .i_inc         (inc[n]),
                .i_dec         (dec[n]),
                .i_invert      (invert[n]),
                .o_dial        (dial[2*n+1:2*n]),
                .o_pos         (pos[POS_W*n +: POS_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dial_quad_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dial_quad_gen
// Description : Directed self-checking bench for dial_quad_gen (2 channels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dial_quad_gen;

    localparam int CHANNELS = 2;
    localparam int DIV_W    = 5;
    localparam int POS_W    = 8;
    localparam int TICK     = 32;

    logic        clk_sys   = 1'b0;
    logic        reset_n   = 1'b1;
    logic        ce        = 1'b0;
    logic        quad_mode = 1'b0;
    logic [1:0]  inc       = 2'b00;
    logic [1:0]  dec       = 2'b00;
    logic [1:0]  invert    = 2'b00;
    logic [3:0]  dial;
    logic [15:0] pos;

    int checks = 0;
    int errors = 0;

    dial_quad_gen #(
        .CHANNELS (CHANNELS),
        .DIV_W    (DIV_W),
        .POS_W    (POS_W)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce        (ce),
        .quad_mode (quad_mode),
        .inc       (inc),
        .dec       (dec),
        .invert    (invert),
        .dial      (dial),
        .pos       (pos)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Leaves the bench 1 unit after an edge with reset released, so the next edge ticks
    task automatic restart(input logic qm, input logic [1:0] i_v, input logic [1:0] d_v,
                           input logic [1:0] v_v);
        reset_n   = 1'b0;
        quad_mode = qm;
        inc       = i_v;
        dec       = d_v;
        invert    = v_v;
        ce        = 1'b1;
        adv(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        check("reset_dial", {12'h0, dial}, 16'h000F);
        check("reset_pos", pos, 16'h0000);
        adv(2);
        ce      = 1'b1;
        inc     = 2'b01;
        reset_n = 1'b1;

`ifndef DIAL_ACCEL_EN
        // Pulse mode, inc[0] held
        adv(1);
        check("pulse_c1_dial", {14'h0, dial[1:0]}, 16'h0002);
        check("pulse_c1_pos", {8'h0, pos[7:0]}, 16'h0001);
        adv(31);
        check("pulse_c32_dial", {14'h0, dial[1:0]}, 16'h0002);
        adv(1);
        check("pulse_c33_dial", {14'h0, dial[1:0]}, 16'h0003);
        adv(TICK);
        check("pulse_c65_dial", {14'h0, dial[1:0]}, 16'h0003);
        adv(TICK);
        check("pulse_c97_dial", {14'h0, dial[1:0]}, 16'h0002);
        check("pulse_c97_pos", {8'h0, pos[7:0]}, 16'h0002);
        check("pulse_ch1_idle", {8'h0, dial[3:2], pos[15:8]}, 16'h0300);

        // Asynchronous reset in the middle of a pulse
        adv(5);
        reset_n = 1'b0;
        #2;
        check("midpulse_rst_dial", {12'h0, dial}, 16'h000F);
        check("midpulse_rst_pos", pos, 16'h0000);

        // Quadrature mode, dec[1] held
        quad_mode = 1'b1;
        inc       = 2'b00;
        dec       = 2'b10;
        adv(2);
        reset_n = 1'b1;
        adv(1);
        check("quad_dn1", {6'h0, dial[3:2], pos[15:8]}, 16'h01FF);
        adv(TICK);
        check("quad_dn2", {6'h0, dial[3:2], pos[15:8]}, 16'h00FE);
        adv(TICK);
        check("quad_dn3", {6'h0, dial[3:2], pos[15:8]}, 16'h02FD);
        adv(TICK);
        check("quad_dn4", {6'h0, dial[3:2], pos[15:8]}, 16'h03FC);
        check("quad_ch0_idle", {6'h0, dial[1:0], pos[7:0]}, 16'h0300);

        // Mode change mid-sequence
        adv(TICK);
        check("quad_dn5", {6'h0, dial[3:2], pos[15:8]}, 16'h01FB);
        adv(2);
        quad_mode = 1'b0;
        adv(1);
        check("modechg_dial_pos", {6'h0, dial[3:2], pos[15:8]}, 16'h03FB);
        adv(29);
        check("modechg_pulse_dn", {6'h0, dial[3:2], pos[15:8]}, 16'h01FA);

        // Conflicting requests, then inverted increment
        restart(1'b0, 2'b01, 2'b01, 2'b00);
        adv(1 + 9 * TICK);
        check("conflict_dial", {12'h0, dial}, 16'h000F);
        check("conflict_pos", pos, 16'h0000);
        invert = 2'b01;
        dec    = 2'b00;
        adv(TICK);
        check("invert_dial", {14'h0, dial[1:0]}, 16'h0001);
        check("invert_pos_wrap", {8'h0, pos[7:0]}, 16'h00FF);

        // Request that appears and vanishes between ticks
        restart(1'b0, 2'b00, 2'b00, 2'b00);
        adv(5);
        inc = 2'b01;
        adv(5);
        inc = 2'b00;
        adv(23);
        check("between_ticks_dial", {12'h0, dial}, 16'h000F);
        check("between_ticks_pos", pos, 16'h0000);

        // Positive wrap 7F -> 80 in quadrature mode
        restart(1'b1, 2'b10, 2'b00, 2'b00);
        adv(1 + 126 * TICK);
        check("wrap_7f", {6'h0, dial[3:2], pos[15:8]}, 16'h017F);
        adv(TICK);
        check("wrap_80", {6'h0, dial[3:2], pos[15:8]}, 16'h0380);

        // Prescaler must freeze while ce is low
        ce = 1'b0;
        adv(100);
        check("ce_hold_pos", {8'h0, pos[15:8]}, 16'h0080);
        ce = 1'b1;
        adv(31);
        check("ce_resume_early", {8'h0, pos[15:8]}, 16'h0080);
        adv(1);
        check("ce_resume_tick", {8'h0, pos[15:8]}, 16'h0081);
`else
        // Acceleration: spacing 4, then 2 from tick 8, then 1 from tick 16
        restart(1'b1, 2'b01, 2'b00, 2'b00);
        adv(1);
        check("accel_t0", {8'h0, pos[7:0]}, 16'h0001);
        adv(3 * TICK);
        check("accel_t3", {8'h0, pos[7:0]}, 16'h0001);
        adv(TICK);
        check("accel_t4", {8'h0, pos[7:0]}, 16'h0002);
        adv(3 * TICK);
        check("accel_t7", {8'h0, pos[7:0]}, 16'h0002);
        adv(TICK);
        check("accel_t8", {8'h0, pos[7:0]}, 16'h0003);
        adv(TICK);
        check("accel_t9", {8'h0, pos[7:0]}, 16'h0003);
        adv(TICK);
        check("accel_t10", {8'h0, pos[7:0]}, 16'h0004);
        adv(5 * TICK);
        check("accel_t15", {8'h0, pos[7:0]}, 16'h0006);
        adv(TICK);
        check("accel_t16", {8'h0, pos[7:0]}, 16'h0007);
        adv(TICK);
        check("accel_t17", {8'h0, pos[7:0]}, 16'h0008);
        adv(22 * TICK);
        check("accel_t39", {8'h0, pos[7:0]}, 16'h001E);
        inc = 2'b00;
        adv(TICK);
        check("accel_release", {8'h0, pos[7:0]}, 16'h001E);
        inc = 2'b01;
        adv(TICK);
        check("accel_restart", {8'h0, pos[7:0]}, 16'h001F);
        adv(3 * TICK);
        check("accel_restart_t3", {8'h0, pos[7:0]}, 16'h001F);
        adv(TICK);
        check("accel_restart_t4", {8'h0, pos[7:0]}, 16'h0020);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
